// File: rtl/metro_pkg.sv
// metro_pkg: shared state encoding, default widths and index-width helper
// for the metro dispense arbiter and gate controller.
`default_nettype none

package metro_pkg;

  localparam int DEF_MONEY_W = 8;
  localparam int DEF_TKT_W   = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT    = 3'd1,
    DISPENSE = 3'd2,
    GAP      = 3'd3,
    DONE     = 3'd4
  } disp_state_t;

  function automatic int term_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/metro_rr_arb.sv
// metro_rr_arb: combinational round-robin picker, first set req at or above ptr,
// wrapping around; rev 1.0.
`default_nettype none

module metro_rr_arb
  import metro_pkg::*;
#(
  parameter int N_TERM = 4,
  parameter int IDX_W  = term_idx_w(N_TERM)
) (
  input  logic [N_TERM-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [N_TERM-1:0] sel,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  int j;

  always_comb begin
    sel   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < N_TERM; k++) begin
      j = int'(ptr) + k;
      if (j >= N_TERM) j = j - N_TERM;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        sel[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/metro_dispense_arbiter.sv
// metro_dispense_arbiter: round-robin sharing of one coin hopper and one ticket
// printer among N_TERM terminals; optional stall timeout via DISP_TIMEOUT_EN; rev 1.0.
`default_nettype none

module metro_dispense_arbiter
  import metro_pkg::*;
#(
  parameter int N_TERM      = 4,
  parameter int MONEY_W     = DEF_MONEY_W,
  parameter int TKT_W       = DEF_TKT_W,
  parameter int PULSE_GAP   = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_TERM-1:0]         req,
  input  logic [N_TERM*MONEY_W-1:0] req_money,
  input  logic [N_TERM*TKT_W-1:0]   req_tkt,
  input  logic                      hopper_ready,
  input  logic                      printer_ready,
  output logic [N_TERM-1:0]         grant,
  output logic [N_TERM-1:0]         done,
  output logic                      coin_pulse,
  output logic                      tkt_pulse,
  output logic                      busy,
  output logic [2:0]                cur_term,
  output logic                      fault
);

  localparam int IDX_W = term_idx_w(N_TERM);

  disp_state_t        state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [N_TERM-1:0]  term_oh;
  logic [MONEY_W-1:0] money_cnt;
  logic [TKT_W-1:0]   tkt_cnt;
  logic [3:0]         gap_cnt;

  logic [N_TERM-1:0]  arb_sel;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  logic [MONEY_W-1:0] money_arr [N_TERM];
  logic [TKT_W-1:0]   tkt_arr   [N_TERM];

  for (genvar i = 0; i < N_TERM; i++) begin : g_unpack
    assign money_arr[i] = req_money[i*MONEY_W +: MONEY_W];
    assign tkt_arr[i]   = req_tkt[i*TKT_W +: TKT_W];
  end

  metro_rr_arb #(
    .N_TERM (N_TERM),
    .IDX_W  (IDX_W)
  ) u_rr_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .sel   (arb_sel),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  logic coin_go;
  logic tkt_go;
  logic counts_zero;

  assign coin_go     = (money_cnt != '0) && hopper_ready;
  assign tkt_go      = (tkt_cnt != '0) && printer_ready;
  assign counts_zero = (money_cnt == '0) && (tkt_cnt == '0);

`ifdef DISP_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign fault          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_idx    <= '0;
      term_oh    <= '0;
      money_cnt  <= '0;
      tkt_cnt    <= '0;
      gap_cnt    <= '0;
      grant      <= '0;
      done       <= '0;
      coin_pulse <= 1'b0;
      tkt_pulse  <= 1'b0;
      busy       <= 1'b0;
      cur_term   <= '0;
`ifdef DISP_TIMEOUT_EN
      stall_cnt  <= '0;
      fault      <= 1'b0;
`endif
    end else begin
      grant      <= '0;
      done       <= '0;
      coin_pulse <= 1'b0;
      tkt_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state    <= GRANT;
            grant    <= arb_sel;
            term_oh  <= arb_sel;
            cur_idx  <= arb_idx;
            cur_term <= 3'(arb_idx);
            busy     <= 1'b1;
`ifdef DISP_TIMEOUT_EN
            fault    <= 1'b0;
`endif
          end
        end
        GRANT: begin
          money_cnt <= money_arr[cur_idx];
          tkt_cnt   <= tkt_arr[cur_idx];
          if ((money_arr[cur_idx] == '0) && (tkt_arr[cur_idx] == '0)) begin
            state <= DONE;
            done  <= term_oh;
          end else begin
            state <= DISPENSE;
          end
        end
        DISPENSE: begin
          if (coin_go) begin
            coin_pulse <= 1'b1;
            money_cnt  <= money_cnt - 1'b1;
          end
          if (tkt_go) begin
            tkt_pulse <= 1'b1;
            tkt_cnt   <= tkt_cnt - 1'b1;
          end
          // GAP includes the pulse cycle itself, so PULSE_GAP low cycles follow each pulse
          if (coin_go || tkt_go) begin
            state   <= GAP;
            gap_cnt <= 4'(PULSE_GAP - 1);
`ifdef DISP_TIMEOUT_EN
            stall_cnt <= '0;
          end else if (stall_cnt == STALL_W'(TIMEOUT_CYC - 1)) begin
            state     <= DONE;
            done      <= term_oh;
            fault     <= 1'b1;
            money_cnt <= '0;
            tkt_cnt   <= '0;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
`endif
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (counts_zero) begin
              state <= DONE;
              done  <= term_oh;
            end else begin
              state <= DISPENSE;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          rr_ptr   <= (cur_idx == IDX_W'(N_TERM - 1)) ? '0 : cur_idx + 1'b1;
          busy     <= 1'b0;
          cur_term <= '0;
          cur_idx  <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
